found_tx_scheduler: RTL and testbench

- Round-robin scheduler between NUM_OF_MODULES tap-search modules and the single shared UART Transmitter.
- Grants one asserted `found` request at a time and captures that module's tap word from `co_buf`.
- Sequences the frame to the Transmitter byte interface: header, module index, tap bytes, trailer.
- Returns a one-cycle acknowledge to the granted module; counts sent and dropped results.

---
 rtl/found_tx_scheduler.sv | 135 +++++++++++++
 tb/tb_found_tx_scheduler.sv | 538 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/found_tx_scheduler.sv
// Round-robin arbiter between tap-search modules and the shared UART
// transmitter: grants one found request, frames its tap word, acks it.
module found_tx_scheduler #(
  parameter int NUM_OF_TAPS    = 5,
  parameter int NUM_OF_MODULES = 20,
  parameter int IDX_W          = 5
) (
  input  logic                                    clk,
  input  logic                                    res,
  input  logic [NUM_OF_MODULES-1:0]               found,
  input  logic [NUM_OF_MODULES*NUM_OF_TAPS*8-1:0] co_buf,
  input  logic                                    tx_ready,
  output logic [7:0]                              byte_out,
  output logic                                    byte_valid,
  output logic [NUM_OF_MODULES-1:0]               ack,
  output logic                                    busy,
  output logic [15:0]                             sent_cnt,
  output logic [7:0]                              drop_cnt
);

  localparam int W    = NUM_OF_TAPS * 8;
  localparam int LAST = NUM_OF_TAPS + 2;
  localparam int CW   = $clog2(LAST + 1);

  typedef enum logic [1:0] {IDLE, LOAD, SEND, ACK} state_t;

  state_t                    state;
  logic [IDX_W-1:0]          rr_ptr;
  logic [IDX_W-1:0]          which;
  logic [IDX_W-1:0]          pick;
  logic                      any;
  logic [CW-1:0]             idx;
  logic [W-1:0]              buff;
  logic [W-1:0]              slice;
  logic                      drop;
  logic [NUM_OF_MODULES-1:0] one_hot;

  // Lowest offset from rr_ptr wins, so scan offsets downward.
  always_comb begin
    int j;
    j    = 0;
    pick = '0;
    any  = 1'b0;
    for (int i = NUM_OF_MODULES - 1; i >= 0; i--) begin
      j = (int'(rr_ptr) + i) % NUM_OF_MODULES;
      if (found[j]) begin
        pick = IDX_W'(j);
        any  = 1'b1;
      end
    end
  end

  assign slice   = co_buf[int'(which)*W +: W];
  assign one_hot = NUM_OF_MODULES'(1) << which;
  assign busy    = (state != IDLE);

  function automatic logic [7:0] frame_byte(
    input logic [CW-1:0]    i,
    input logic [IDX_W-1:0] w,
    input logic [W-1:0]     b
  );
    logic [7:0] r;
    unique case (1'b1)
      (i == CW'(0)):    r = 8'hFF;
      (i == CW'(1)):    r = 8'(w);
      (i == CW'(LAST)): r = 8'hFE;
      default:          r = b[(int'(i)-2)*8 +: 8];
    endcase
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (res) begin
      state      <= IDLE;
      byte_out   <= 8'h11;
      byte_valid <= 1'b0;
      ack        <= '0;
      sent_cnt   <= '0;
      drop_cnt   <= '0;
      rr_ptr     <= '0;
      which      <= '0;
      idx        <= '0;
      buff       <= '0;
      drop       <= 1'b0;
    end else begin
      ack <= '0;
      unique case (state)
        IDLE: begin
          if (any) begin
            which  <= pick;
            rr_ptr <= (pick == IDX_W'(NUM_OF_MODULES-1)) ?
                      '0 : pick + 1'b1;
            state  <= LOAD;
          end
        end
        LOAD: begin
          buff <= slice;
          if (slice == '0 || slice[7:0] == 8'h00) begin
            drop  <= 1'b1;
            ack   <= one_hot;
            state <= ACK;
          end else begin
            drop       <= 1'b0;
            idx        <= '0;
            byte_out   <= 8'hFF;
            byte_valid <= 1'b1;
            state      <= SEND;
          end
        end
        SEND: begin
          if (tx_ready) begin
            if (idx == CW'(LAST)) begin
              byte_valid <= 1'b0;
              ack        <= one_hot;
              state      <= ACK;
            end else begin
              idx      <= idx + 1'b1;
              byte_out <= frame_byte(idx + 1'b1, which, buff);
            end
          end
        end
        ACK: begin
          if (!drop) begin
            if (sent_cnt != '1) sent_cnt <= sent_cnt + 1'b1;
          end else begin
            if (drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_found_tx_scheduler.sv
// Self-checking bench for found_tx_scheduler (2 taps, 4 modules):
// directed scenarios plus randomized rounds against a queue model.
module tb_found_tx_scheduler;

  logic        clk = 1'b0;
  logic        res;
  logic [3:0]  found;
  logic [63:0] co_buf;
  logic        tx_ready;
  logic [7:0]  byte_out;
  logic        byte_valid;
  logic [3:0]  ack;
  logic        busy;
  logic [15:0] sent_cnt;
  logic [7:0]  drop_cnt;
  logic [15:0] word [4];

  int total;
  int bad;

  assign co_buf = {word[3], word[2], word[1], word[0]};

  found_tx_scheduler #(
    .NUM_OF_TAPS(2),
    .NUM_OF_MODULES(4),
    .IDX_W(2)
  ) dut (
    .clk(clk),
    .res(res),
    .found(found),
    .co_buf(co_buf),
    .tx_ready(tx_ready),
    .byte_out(byte_out),
    .byte_valid(byte_valid),
    .ack(ack),
    .busy(busy),
    .sent_cnt(sent_cnt),
    .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Frame byte k for module m carrying tap word w.
  function automatic logic [7:0] fbyte(int m, logic [15:0] w, int k);
    case (k)
      0:       return 8'hFF;
      1:       return 8'(m);
      2:       return w[7:0];
      3:       return w[15:8];
      default: return 8'hFE;
    endcase
  endfunction

  function automatic logic [15:0] valid_word();
    return {8'($urandom), 8'($urandom_range(1, 255))};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    found    = '0;
    tx_ready = 1'b0;
    res      = 1'b1;
    step();
    step();
    res = 1'b0;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 4; i++) word[i] = '0;
    do_reset();
    total += 6;
    if (byte_out !== 8'h11) begin
      bad++; $display("FAIL reset byte_out got=%h want=11", byte_out);
    end
    if (byte_valid !== 1'b0) begin
      bad++; $display("FAIL reset byte_valid got=%b want=0", byte_valid);
    end
    if (ack !== 4'b0) begin
      bad++; $display("FAIL reset ack got=%b want=0000", ack);
    end
    if (busy !== 1'b0) begin
      bad++; $display("FAIL reset busy got=%b want=0", busy);
    end
    if (sent_cnt !== 16'h0) begin
      bad++; $display("FAIL reset sent_cnt got=%h want=0", sent_cnt);
    end
    if (drop_cnt !== 8'h0) begin
      bad++; $display("FAIL reset drop_cnt got=%h want=0", drop_cnt);
    end
  endtask

  task automatic test_single();
    do_reset();
    word[2]  = 16'hBEEF;
    tx_ready = 1'b1;
    found    = 4'b0100;
    step();
    total += 2;
    if (byte_valid !== 1'b0) begin
      bad++; $display("FAIL single load_valid got=%b want=0", byte_valid);
    end
    if (busy !== 1'b1) begin
      bad++; $display("FAIL single load_busy got=%b want=1", busy);
    end
    for (int k = 0; k < 5; k++) begin
      step();
      total++;
      if (byte_valid !== 1'b1 || byte_out !== fbyte(2, 16'hBEEF, k)) begin
        bad++;
        $display("FAIL single byte%0d got=%b/%h want=1/%h",
                 k, byte_valid, byte_out, fbyte(2, 16'hBEEF, k));
      end
    end
    step();
    total += 2;
    if (ack !== 4'b0100) begin
      bad++; $display("FAIL single ack got=%b want=0100", ack);
    end
    if (byte_valid !== 1'b0) begin
      bad++; $display("FAIL single ack_valid got=%b want=0", byte_valid);
    end
    found = '0;
    step();
    total += 3;
    if (ack !== 4'b0) begin
      bad++; $display("FAIL single ack_len got=%b want=0000", ack);
    end
    if (sent_cnt !== 16'd1) begin
      bad++; $display("FAIL single sent_cnt got=%0d want=1", sent_cnt);
    end
    if (busy !== 1'b0) begin
      bad++; $display("FAIL single idle_busy got=%b want=0", busy);
    end
  endtask

  task automatic test_all_held();
    logic [3:0] order[$];
    logic [3:0] want[5];
    bit armed;
    want = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    armed = 1'b0;
    do_reset();
    for (int i = 0; i < 4; i++) word[i] = valid_word();
    tx_ready = 1'b1;
    found    = 4'hF;
    for (int c = 0; c < 200 && order.size() < 5; c++) begin
      step();
      if (ack !== 4'b0) begin
        order.push_back(ack);
        found = found & ~ack;
        if (ack === 4'b0100) armed = 1'b1;
      end else if (armed && byte_valid) begin
        found[0] = 1'b1;
        armed    = 1'b0;
      end
    end
    found = '0;
    total++;
    if (order.size() != 5) begin
      bad++; $display("FAIL all_held grants got=%0d want=5", order.size());
    end
    for (int i = 0; i < 5; i++) begin
      if (i < order.size()) begin
        total++;
        if (order[i] !== want[i]) begin
          bad++;
          $display("FAIL all_held grant%0d got=%b want=%b",
                   i, order[i], want[i]);
        end
      end
    end
    step();
    total++;
    if (sent_cnt !== 16'd5) begin
      bad++; $display("FAIL all_held sent_cnt got=%0d want=5", sent_cnt);
    end
  endtask

  task automatic test_backpressure();
    logic [7:0]  got[$];
    logic [15:0] w;
    logic        prev_v, prev_r;
    logic [7:0]  prev_b;
    bit          seen;
    int          phase;
    do_reset();
    w       = valid_word();
    word[0] = w;
    found   = 4'b0001;
    seen    = 1'b0;
    phase   = 0;
    prev_v  = 1'b0;
    prev_r  = 1'b0;
    prev_b  = 8'h00;
    for (int c = 0; c < 100 && !seen; c++) begin
      step();
      if (prev_v && !prev_r) begin
        total++;
        if (byte_valid !== 1'b1 || byte_out !== prev_b) begin
          bad++;
          $display("FAIL backpressure stall got=%b/%h want=1/%h",
                   byte_valid, byte_out, prev_b);
        end
      end
      if (ack !== 4'b0) begin
        total++;
        if (ack !== 4'b0001) begin
          bad++; $display("FAIL backpressure ack got=%b want=0001", ack);
        end
        found = '0;
        seen  = 1'b1;
      end
      tx_ready = (phase % 3 == 0);
      phase++;
      if (byte_valid && tx_ready) got.push_back(byte_out);
      prev_v = byte_valid;
      prev_b = byte_out;
      prev_r = tx_ready;
    end
    total += 2;
    if (!seen) begin
      bad++; $display("FAIL backpressure ack_timeout got=none want=0001");
    end
    if (got.size() != 5) begin
      bad++; $display("FAIL backpressure count got=%0d want=5", got.size());
    end
    for (int k = 0; k < 5 && k < got.size(); k++) begin
      total++;
      if (got[k] !== fbyte(0, w, k)) begin
        bad++;
        $display("FAIL backpressure byte%0d got=%h want=%h",
                 k, got[k], fbyte(0, w, k));
      end
    end
    tx_ready = 1'b1;
    step();
  endtask

  task automatic test_invalid();
    int nv;
    do_reset();
    nv       = 0;
    tx_ready = 1'b1;
    word[1]  = 16'h1200;
    found    = 4'b0010;
    step();
    if (byte_valid) nv++;
    total++;
    if (ack !== 4'b0) begin
      bad++; $display("FAIL invalid early_ack got=%b want=0000", ack);
    end
    step();
    if (byte_valid) nv++;
    total++;
    if (ack !== 4'b0010) begin
      bad++; $display("FAIL invalid ack got=%b want=0010", ack);
    end
    found = '0;
    step();
    if (byte_valid) nv++;
    total += 3;
    if (drop_cnt !== 8'd1) begin
      bad++; $display("FAIL invalid drop_cnt got=%0d want=1", drop_cnt);
    end
    if (sent_cnt !== 16'd0) begin
      bad++; $display("FAIL invalid sent_cnt got=%0d want=0", sent_cnt);
    end
    if (ack !== 4'b0) begin
      bad++; $display("FAIL invalid ack_len got=%b want=0000", ack);
    end
    word[3] = 16'h0000;
    found   = 4'b1000;
    step();
    if (byte_valid) nv++;
    step();
    if (byte_valid) nv++;
    total++;
    if (ack !== 4'b1000) begin
      bad++; $display("FAIL invalid zero_ack got=%b want=1000", ack);
    end
    found = '0;
    step();
    total += 2;
    if (drop_cnt !== 8'd2) begin
      bad++; $display("FAIL invalid zero_drop got=%0d want=2", drop_cnt);
    end
    if (nv != 0) begin
      bad++; $display("FAIL invalid byte_valid got=%0d cycles want=0", nv);
    end
  endtask

  task automatic test_reset_mid();
    bit seen;
    word[2]  = valid_word();
    tx_ready = 1'b1;
    found    = 4'b0100;
    step();
    step();
    step();
    total++;
    if (byte_out !== 8'h02) begin
      bad++; $display("FAIL reset_mid second_byte got=%h want=02", byte_out);
    end
    step();
    res   = 1'b1;
    found = '0;
    total++;
    if (ack !== 4'b0) begin
      bad++; $display("FAIL reset_mid pre_ack got=%b want=0000", ack);
    end
    step();
    res = 1'b0;
    total += 6;
    if (byte_valid !== 1'b0) begin
      bad++; $display("FAIL reset_mid valid got=%b want=0", byte_valid);
    end
    if (byte_out !== 8'h11) begin
      bad++; $display("FAIL reset_mid byte_out got=%h want=11", byte_out);
    end
    if (sent_cnt !== 16'd0) begin
      bad++; $display("FAIL reset_mid sent_cnt got=%0d want=0", sent_cnt);
    end
    if (drop_cnt !== 8'd0) begin
      bad++; $display("FAIL reset_mid drop_cnt got=%0d want=0", drop_cnt);
    end
    if (ack !== 4'b0) begin
      bad++; $display("FAIL reset_mid ack got=%b want=0000", ack);
    end
    if (busy !== 1'b0) begin
      bad++; $display("FAIL reset_mid busy got=%b want=0", busy);
    end
    word[1] = valid_word();
    word[3] = valid_word();
    found   = 4'b1010;
    seen    = 1'b0;
    for (int c = 0; c < 50 && !seen; c++) begin
      step();
      if (ack !== 4'b0) begin
        seen = 1'b1;
        total++;
        if (ack !== 4'b0010) begin
          bad++; $display("FAIL reset_mid regrant got=%b want=0010", ack);
        end
        found = found & ~ack;
      end
    end
    total++;
    if (!seen) begin
      bad++; $display("FAIL reset_mid regrant_timeout got=none want=0010");
    end
    found = '0;
    for (int c = 0; c < 20; c++) step();
  endtask

  task automatic test_random();
    int          ptr, msent, mdrop, m;
    logic [3:0]  f, rem;
    int          exp_acks[$];
    logic [7:0]  exp_bytes[$];
    logic        prev_v, prev_r;
    logic [7:0]  prev_b;
    do_reset();
    ptr   = 0;
    msent = 0;
    mdrop = 0;
    prev_v = 1'b0;
    prev_r = 1'b0;
    prev_b = 8'h00;
    for (int r = 0; r < 25; r++) begin
      f   = 4'($urandom_range(1, 15));
      rem = f;
      for (int i = 0; i < 4; i++) begin
        if ($urandom_range(0, 3) == 0) word[i] = {8'($urandom), 8'h00};
        else word[i] = valid_word();
      end
      while (rem != 0) begin
        m = -1;
        for (int i = 0; i < 4 && m < 0; i++)
          if (rem[(ptr + i) % 4]) m = (ptr + i) % 4;
        rem[m] = 1'b0;
        ptr    = (m + 1) % 4;
        exp_acks.push_back(m);
        if (word[m][7:0] == 8'h00) mdrop++;
        else begin
          msent++;
          for (int k = 0; k < 5; k++) exp_bytes.push_back(fbyte(m, word[m], k));
        end
      end
      found = f;
      for (int c = 0; c < 400 && exp_acks.size() > 0; c++) begin
        step();
        if (prev_v && !prev_r) begin
          total++;
          if (byte_valid !== 1'b1 || byte_out !== prev_b) begin
            bad++;
            $display("FAIL random stall got=%b/%h want=1/%h",
                     byte_valid, byte_out, prev_b);
          end
        end
        if (ack !== 4'b0) begin
          total++;
          if (ack !== (4'(1) << exp_acks[0])) begin
            bad++;
            $display("FAIL random ack got=%b want=%b",
                     ack, 4'(1) << exp_acks[0]);
          end
          void'(exp_acks.pop_front());
          found = found & ~ack;
        end
        tx_ready = 1'($urandom_range(0, 1));
        if (byte_valid && tx_ready) begin
          total++;
          if (exp_bytes.size() == 0) begin
            bad++; $display("FAIL random extra_byte got=%h want=none", byte_out);
          end else if (byte_out !== exp_bytes[0]) begin
            bad++;
            $display("FAIL random byte got=%h want=%h", byte_out, exp_bytes[0]);
            void'(exp_bytes.pop_front());
          end else void'(exp_bytes.pop_front());
        end
        prev_v = byte_valid;
        prev_b = byte_out;
        prev_r = tx_ready;
      end
      total++;
      if (exp_acks.size() != 0 || exp_bytes.size() != 0) begin
        bad++;
        $display("FAIL random round%0d left got=%0d acks/%0d bytes want=0/0",
                 r, exp_acks.size(), exp_bytes.size());
        exp_acks.delete();
        exp_bytes.delete();
      end
      found = '0;
      step();
      prev_v = byte_valid;
      prev_b = byte_out;
      prev_r = tx_ready;
    end
    total += 2;
    if (sent_cnt !== 16'(msent)) begin
      bad++; $display("FAIL random sent_cnt got=%0d want=%0d", sent_cnt, msent);
    end
    if (drop_cnt !== 8'(mdrop)) begin
      bad++; $display("FAIL random drop_cnt got=%0d want=%0d", drop_cnt, mdrop);
    end
  endtask

  task automatic test_saturation();
    int  misses;
    bit  seen;
    do_reset();
    tx_ready = 1'b1;
    misses   = 0;
    for (int i = 0; i < 300; i++) begin
      word[i % 4] = 16'hAB00;
      found = 4'(1) << (i % 4);
      seen  = 1'b0;
      for (int c = 0; c < 10 && !seen; c++) begin
        step();
        if (ack !== 4'b0) seen = 1'b1;
      end
      found = '0;
      if (!seen) misses++;
      step();
    end
    total += 3;
    if (misses != 0) begin
      bad++; $display("FAIL saturation drop_timeouts got=%0d want=0", misses);
    end
    if (drop_cnt !== 8'hFF) begin
      bad++; $display("FAIL saturation drop_cnt got=%h want=FF", drop_cnt);
    end
    if (sent_cnt !== 16'h0) begin
      bad++; $display("FAIL saturation sent_idle got=%h want=0", sent_cnt);
    end
    force dut.sent_cnt = 16'hFFFC;
    #1;
    release dut.sent_cnt;
    misses = 0;
    for (int i = 0; i < 6; i++) begin
      word[i % 4] = valid_word();
      found = 4'(1) << (i % 4);
      seen  = 1'b0;
      for (int c = 0; c < 30 && !seen; c++) begin
        step();
        if (ack !== 4'b0) seen = 1'b1;
      end
      found = '0;
      if (!seen) misses++;
      step();
      if (i == 2) begin
        total++;
        if (sent_cnt !== 16'hFFFF) begin
          bad++; $display("FAIL saturation sent_top got=%h want=FFFF", sent_cnt);
        end
      end
    end
    total += 3;
    if (misses != 0) begin
      bad++; $display("FAIL saturation sent_timeouts got=%0d want=0", misses);
    end
    if (sent_cnt !== 16'hFFFF) begin
      bad++; $display("FAIL saturation sent_hold got=%h want=FFFF", sent_cnt);
    end
    if (drop_cnt !== 8'hFF) begin
      bad++; $display("FAIL saturation drop_hold got=%h want=FF", drop_cnt);
    end
  endtask

  initial begin
    total    = 0;
    bad      = 0;
    res      = 1'b0;
    found    = '0;
    tx_ready = 1'b0;
    test_reset();
    test_single();
    test_all_held();
    test_backpressure();
    test_invalid();
    test_reset_mid();
    test_random();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
